mem_stream_reader: RTL and testbench



---
 rtl/mem_stream_reader.sv | 174 +++++++++++++++++
 tb/tb_mem_stream_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Strided read DMA: walks the banked data memory from a flat pointer and streams the
// returned words out through a 2-entry skid FIFO with valid/ready/last handshaking.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only produces a done pulse
// RUN   | issuing reads and draining the output FIFO
// FLUSH | one cycle after abort; FIFO already cleared, no done pulse
module mem_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BANKS  = 8,
    parameter int MEM_SIZE   = 16384,
    parameter int LEN_WIDTH  = 16,
    parameter int PTR_W      = $clog2(MEM_SIZE),
    parameter int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PTR_W-1:0]      cfg_base,
    input  logic [PTR_W-1:0]      cfg_stride,
    input  logic [LEN_WIDTH-1:0]  cfg_length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BANK_W-1:0]     mem_bank_sel,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int BANK_SIZE = MEM_SIZE / NUM_BANKS;
    localparam int OFF_W     = $clog2(BANK_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      stride_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic                  inflight;
    logic                  inflight_last;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  rd_idx;
    logic                  wr_idx;
    logic [1:0]            count;

    logic                  start_go;
    logic                  start_empty;
    logic                  pop;
    logic                  push;
    logic                  room;
    logic                  issue;
    logic                  issue_last;
    logic                  finish;
    logic                  run_live;
    logic [PTR_W-1:0]      issue_ptr;

    // The first read goes out in the start cycle itself so the first word
    // reaches the stream two cycles after start.
    assign start_go    = (state == IDLE) && start && (cfg_length != '0);
    assign start_empty = (state == IDLE) && start && (cfg_length == '0);
    assign run_live    = (state == RUN) && !abort;

    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_idx];
    assign out_last  = fifo_last[rd_idx] && out_valid;
    assign pop       = out_valid && out_ready;
    assign push      = inflight && run_live;

    // Occupancy after this cycle, crediting a pop happening now, must leave room
    // for the word about to be requested; keeps 1 word/cycle with out_ready high.
    assign room  = ({1'b0, count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;
    assign issue = start_go || (run_live && (issued != len_q) && room);

    assign issue_ptr  = start_go ? cfg_base : ptr;
    assign issue_last = start_go ? (cfg_length == LEN_WIDTH'(1))
                                 : ((issued + LEN_WIDTH'(1)) == len_q);
    assign finish     = run_live && pop && out_last;

    assign mem_read_en  = issue;
    assign mem_bank_sel = issue_ptr[PTR_W-1 -: BANK_W];

    always_comb begin
        mem_addr = '0;
        mem_addr[OFF_W-1:0] = issue_ptr[OFF_W-1:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_go) state_next = RUN;
            RUN: begin
                if (abort)       state_next = FLUSH;
                else if (finish) state_next = IDLE;
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr           <= '0;
            stride_q      <= '0;
            len_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_idx        <= 1'b0;
            wr_idx        <= 1'b0;
            count         <= 2'd0;
            done          <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            done          <= start_empty || finish;
            inflight      <= issue;
            inflight_last <= issue && issue_last;

            if (start_go) begin
                stride_q <= cfg_stride;
                len_q    <= cfg_length;
            end

            if (issue) begin
                ptr    <= issue_ptr + (start_go ? cfg_stride : stride_q);
                issued <= start_go ? LEN_WIDTH'(1) : issued + LEN_WIDTH'(1);
            end

            // Abort drops buffered words and whatever read is returning this cycle.
            if ((state == RUN) && abort) begin
                rd_idx <= 1'b0;
                wr_idx <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    fifo_data[wr_idx] <= mem_read_data;
                    fifo_last[wr_idx] <= inflight_last;
                    wr_idx            <= ~wr_idx;
                end
                if (pop) begin
                    rd_idx <= ~rd_idx;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: a behavioural 1-cycle-latency memory plus
// per-scenario hand-computed expectations for reads, stream words, last and done.
module tb_mem_stream_reader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NB = 8;
    localparam int MS = 16384;
    localparam int LW = 16;
    localparam int PW = 14;
    localparam int BW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PW-1:0] cfg_base;
    logic [PW-1:0] cfg_stride;
    logic [LW-1:0] cfg_length;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_bank_sel;
    logic          mem_read_en;
    logic [DW-1:0] mem_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    mem_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .MEM_SIZE(MS), .LEN_WIDTH(LW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_length(cfg_length),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_bank_sel(mem_bank_sel), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [MS];

    always @(posedge clock) begin
        if (reset) mem_read_data <= '0;
        else if (mem_read_en) mem_read_data <= mem[{mem_bank_sel, mem_addr[10:0]}];
    end

    int checks = 0;
    int errors = 0;

    int          rd_bank_q[$];
    int          rd_addr_q[$];
    logic [31:0] acc_data_q[$];
    int          acc_last_q[$];
    int          valid_q[$];
    int          busy_q[$];
    int first_valid, done_cyc, done_cnt, stall_err, max_out, last_acc_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_val({pfx, "_busy"},     32'(busy),         32'd0);
        check_val({pfx, "_done"},     32'(done),         32'd0);
        check_val({pfx, "_rd_en"},    32'(mem_read_en),  32'd0);
        check_val({pfx, "_valid"},    32'(out_valid),    32'd0);
        check_val({pfx, "_last"},     32'(out_last),     32'd0);
        check_val({pfx, "_addr"},     32'(mem_addr),     32'd0);
        check_val({pfx, "_bank"},     32'(mem_bank_sel), 32'd0);
        check_val({pfx, "_data"},     out_data,          32'd0);
    endtask

    // ready_mode 0: always ready; 1: ready pattern 1,0,0,1 repeating.
    task automatic run_xfer(input logic [PW-1:0] base, input logic [PW-1:0] stride,
                            input logic [LW-1:0] len, input int ready_mode,
                            input int abort_at, input int ncyc);
        int issued_n, accepted_n;
        logic held_valid, held_last;
        logic [31:0] held_data;
        rd_bank_q.delete(); rd_addr_q.delete(); acc_data_q.delete(); acc_last_q.delete();
        valid_q.delete(); busy_q.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0; stall_err = 0; max_out = 0;
        last_acc_cyc = -1; issued_n = 0; accepted_n = 0;
        held_valid = 1'b0; held_last = 1'b0; held_data = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            start      = (cyc == 0);
            abort      = (cyc == abort_at);
            cfg_base   = base;
            cfg_stride = stride;
            cfg_length = len;
            out_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            @(negedge clock);
            if (held_valid && (!out_valid || out_data !== held_data || out_last !== held_last))
                stall_err++;
            if (mem_read_en) begin
                rd_bank_q.push_back(int'(mem_bank_sel));
                rd_addr_q.push_back(int'(mem_addr));
                issued_n++;
            end
            valid_q.push_back(int'(out_valid));
            busy_q.push_back(int'(busy));
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                acc_data_q.push_back(out_data);
                acc_last_q.push_back(int'(out_last));
                accepted_n++;
                last_acc_cyc = cyc;
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
            if (issued_n - accepted_n > max_out) max_out = issued_n - accepted_n;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_basic(input string pfx);
        check_val({pfx, "_nreads"}, 32'(rd_bank_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_addr%0d", pfx, i), 32'(rd_addr_q[i]), 32'd5 + 32'(i));
            check_val($sformatf("%s_data%0d", pfx, i), acc_data_q[i], 32'h105 + 32'(i));
            check_val($sformatf("%s_last%0d", pfx, i), 32'(acc_last_q[i]), (i == 3) ? 32'd1 : 32'd0);
        end
        check_val({pfx, "_first_valid"}, 32'(first_valid), 32'd2);
        check_val({pfx, "_done_cyc"}, 32'(done_cyc), 32'd6);
        check_val({pfx, "_done_after_last"}, 32'(done_cyc - last_acc_cyc), 32'd1);
        check_val({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_val({pfx, "_busy_c1"}, 32'(busy_q[1]), 32'd1);
        check_val({pfx, "_busy_at_done"}, 32'(busy_q[6]), 32'd0);
    endtask

    initial begin
        int busy_any;
        for (int i = 0; i < MS; i++) mem[i] = 32'h100 + 32'(i);
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        cfg_base = '0; cfg_stride = '0; cfg_length = '0;
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // basic
        run_xfer(14'd5, 14'd1, 16'd4, 0, -1, 10);
        check_basic("basic");

        // bank crossing
        run_xfer(14'd2046, 14'd1, 16'd3, 0, -1, 10);
        check_val("xbank_nreads", 32'(rd_bank_q.size()), 32'd3);
        check_val("xbank_b0", 32'(rd_bank_q[0]), 32'd0);
        check_val("xbank_a0", 32'(rd_addr_q[0]), 32'd2046);
        check_val("xbank_b1", 32'(rd_bank_q[1]), 32'd0);
        check_val("xbank_a1", 32'(rd_addr_q[1]), 32'd2047);
        check_val("xbank_b2", 32'(rd_bank_q[2]), 32'd1);
        check_val("xbank_a2", 32'(rd_addr_q[2]), 32'd0);
        check_val("xbank_d0", acc_data_q[0], 32'h8FE);
        check_val("xbank_d2", acc_data_q[2], 32'h900);
        check_val("xbank_done", 32'(done_cnt), 32'd1);

        // pointer wrap
        run_xfer(14'd16383, 14'd2, 16'd2, 0, -1, 10);
        check_val("wrap_nreads", 32'(rd_bank_q.size()), 32'd2);
        check_val("wrap_b0", 32'(rd_bank_q[0]), 32'd7);
        check_val("wrap_a0", 32'(rd_addr_q[0]), 32'd2047);
        check_val("wrap_b1", 32'(rd_bank_q[1]), 32'd0);
        check_val("wrap_a1", 32'(rd_addr_q[1]), 32'd1);
        check_val("wrap_d0", acc_data_q[0], 32'h40FF);
        check_val("wrap_d1", acc_data_q[1], 32'h101);
        check_val("wrap_last1", 32'(acc_last_q[1]), 32'd1);

        // backpressure
        run_xfer(14'd100, 14'd1, 16'd6, 1, -1, 40);
        check_val("bp_nwords", 32'(acc_data_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("bp_data%0d", i), acc_data_q[i], 32'h164 + 32'(i));
            check_val($sformatf("bp_last%0d", i), 32'(acc_last_q[i]), (i == 5) ? 32'd1 : 32'd0);
        end
        check_val("bp_stall_stable", 32'(stall_err), 32'd0);
        check_val("bp_max_outstanding", 32'(max_out), 32'd2);
        check_val("bp_done_cnt", 32'(done_cnt), 32'd1);

        // zero length
        run_xfer(14'd9, 14'd1, 16'd0, 0, -1, 5);
        busy_any = 0;
        foreach (busy_q[i]) busy_any += busy_q[i];
        check_val("zero_done_cyc", 32'(done_cyc), 32'd1);
        check_val("zero_done_cnt", 32'(done_cnt), 32'd1);
        check_val("zero_nreads", 32'(rd_bank_q.size()), 32'd0);
        check_val("zero_busy", 32'(busy_any), 32'd0);

        // stride zero
        run_xfer(14'd7, 14'd0, 16'd3, 0, -1, 10);
        check_val("s0_nwords", 32'(acc_data_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("s0_data%0d", i), acc_data_q[i], 32'h107);
            check_val($sformatf("s0_addr%0d", i), 32'(rd_addr_q[i]), 32'd7);
        end
        check_val("s0_done_cnt", 32'(done_cnt), 32'd1);

        // abort on third cycle, then restart
        run_xfer(14'd50, 14'd1, 16'd10, 0, 2, 8);
        check_val("abort_valid_c2", 32'(valid_q[2]), 32'd1);
        check_val("abort_valid_c3", 32'(valid_q[3]), 32'd0);
        check_val("abort_valid_c4", 32'(valid_q[4]), 32'd0);
        check_val("abort_busy_c1", 32'(busy_q[1]), 32'd1);
        check_val("abort_busy_c5", 32'(busy_q[5]), 32'd0);
        check_val("abort_no_done", 32'(done_cnt), 32'd0);

        run_xfer(14'd200, 14'd1, 16'd2, 0, -1, 8);
        check_val("restart_nwords", 32'(acc_data_q.size()), 32'd2);
        check_val("restart_d0", acc_data_q[0], 32'h1C8);
        check_val("restart_d1", acc_data_q[1], 32'h1C9);
        check_val("restart_last1", 32'(acc_last_q[1]), 32'd1);
        check_val("restart_done_cyc", 32'(done_cyc), 32'd4);

        // reset mid-transfer with the FIFO full
        start = 1'b1; cfg_base = 14'd300; cfg_stride = 14'd1; cfg_length = 16'd8;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        check_val("midrst_pre_valid", 32'(out_valid), 32'd1);
        check_val("midrst_pre_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check_outputs_zero("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        run_xfer(14'd5, 14'd1, 16'd4, 0, -1, 10);
        check_basic("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
